// File: rtl/aes_uart_pkg.sv
// Shared definitions for the block UART transmitter: frame constants,
// default bit time and the transmitter state encoding.
// Optional feature macro: BLOCK_UART_TX_PARITY_EN (adds an even-parity state).
package aes_uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int BLOCK_BYTES          = 16;
    localparam int BLOCK_BITS           = 128;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef BLOCK_UART_TX_PARITY_EN
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
`else
        ST_STOP   = 3'd3
`endif
    } tx_state_e;

    // Even parity over one data byte (1 when the byte holds an odd number of ones).
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/block_uart_tx_baud_tick.sv
// Bit-time generator: counts CLKS_PER_BIT cycles and pulses tick on the
// last cycle of each bit. A synchronous clear holds the count at zero so
// the first bit after clear lasts exactly CLKS_PER_BIT cycles.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: hold at zero while cleared, wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = 16'd0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Baud counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/block_uart_tx.sv
// Block UART transmitter: sends a captured 128-bit block as 16 back-to-back
// 8N1 frames, most significant byte first, each byte LSB first.
// Optional feature macro: BLOCK_UART_TX_PARITY_EN (8E1 frames).
module block_uart_tx
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BLOCK_BITS-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  data_out_tx
);

    tx_state_e             state_q, state_d;
    logic [BLOCK_BITS-1:0] shift_q, shift_d;
    logic [3:0]            byte_q, byte_d;
    logic [2:0]            bit_q, bit_d;
    logic                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  tick_s;
    logic                  clr_s;
    logic [7:0]            cur_byte_s;
    logic [2:0]            bit_nxt_s;

    assign clr_s      = (state_q == ST_IDLE);
    assign cur_byte_s = shift_q[BLOCK_BITS-1 -: 8];
    assign bit_nxt_s  = bit_q + 3'd1;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .tick(tick_s)
    );

    // Frame sequencing; line, busy and done are computed for the next cycle
    // so that all outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        line_d  = line_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    shift_d = data_in;
                    byte_d  = 4'd0;
                    bit_d   = 3'd0;
                    state_d = ST_START;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    line_d  = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    line_d  = cur_byte_s[0];
                end else begin
                    line_d  = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef BLOCK_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        line_d  = even_parity(cur_byte_s);
`else
                        state_d = ST_STOP;
                        line_d  = IDLE_LEVEL;
`endif
                    end else begin
                        bit_d  = bit_nxt_s;
                        line_d = cur_byte_s[bit_nxt_s];
                    end
                end else begin
                    line_d = line_q;
                end
            end
`ifdef BLOCK_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                    line_d  = IDLE_LEVEL;
                end else begin
                    line_d  = line_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (byte_q == 4'(BLOCK_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        line_d  = IDLE_LEVEL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next byte moves into the top of the shift register.
                        byte_d  = byte_q + 4'd1;
                        shift_d = {shift_q[BLOCK_BITS-9:0], 8'h00};
                        state_d = ST_START;
                        line_d  = 1'b0;
                    end
                end else begin
                    line_d = IDLE_LEVEL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; ready_q blocks start for one
    // cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            byte_q  <= 4'd0;
            bit_q   <= 3'd0;
            line_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign data_out_tx = line_q;

endmodule

// File: tb/tb_block_uart_tx.sv
// Directed bench for block_uart_tx with CLKS_PER_BIT=4.
module tb_block_uart_tx;

    localparam int N = 4;
`ifdef BLOCK_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BLK = 16 * FB * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic         data_out_tx;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] data;
        logic [127:0] exp;
        int           repulse;
    } vec_t;

    vec_t vecs[5];

    block_uart_tx #(
        .CLKS_PER_BIT(N),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .data_out_tx(data_out_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for bit j of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        logic r;
        if (j == 0)                    r = 1'b0;
        else if (j <= 8)               r = b[j-1];
        else if (FB == 11 && j == 9)   r = ^b;
        else                           r = 1'b1;
        return r;
    endfunction

    // Follows one whole block from the cycle busy rises to the done pulse.
    task automatic check_block(input logic [127:0] exp, input int repulse_at,
                               input bit hold, input int exp_wait, input string name);
        int       waits;
        int       frame_err[16];
        int       busy_err;
        int       done_err;
        logic [7:0] dec[16];
        busy_err = 0;
        done_err = 0;
        for (int f = 0; f < 16; f++) begin
            frame_err[f] = 0;
            dec[f] = 8'h00;
        end
        @(negedge clk);
        waits = 1;
        while (busy !== 1'b1 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (busy !== 1'b1) begin
            check({name, "_start_timeout"}, 128'(busy), 128'd1);
            return;
        end
        check({name, "_start_latency"}, 128'(waits), 128'(exp_wait));
        if (!hold) start = 1'b0;
        for (int k = 0; k <= BLK; k++) begin
            if (k > 0) @(negedge clk);
            if (repulse_at >= 0 && k == repulse_at) begin
                start   = 1'b1;
                data_in = ~data_in;
            end else if (repulse_at >= 0 && k == repulse_at + 1) begin
                start = 1'b0;
            end
            if (k < BLK) begin
                int bn;
                int f;
                int j;
                bn = k / N;
                f  = bn / FB;
                j  = bn % FB;
                if (data_out_tx !== exp_bit(exp[127-8*f -: 8], j)) frame_err[f]++;
                if (j >= 1 && j <= 8 && (k % N) == N/2) dec[f][j-1] = data_out_tx;
                if (busy !== 1'b1) busy_err++;
                if (done !== 1'b0) done_err++;
            end
        end
        check({name, "_done_at_end"}, 128'(done), 128'd1);
        check({name, "_busy_at_end"}, 128'(busy), 128'd0);
        check({name, "_line_at_end"}, 128'(data_out_tx), 128'd1);
        check({name, "_busy_errs"},   128'(busy_err), 128'd0);
        check({name, "_early_done"},  128'(done_err), 128'd0);
        for (int f = 0; f < 16; f++) begin
            check($sformatf("%s_frame%0d_bits", name, f), 128'(frame_err[f]), 128'd0);
            check($sformatf("%s_frame%0d_byte", name, f), 128'(dec[f]), 128'(exp[127-8*f -: 8]));
        end
        if (!hold) begin
            @(negedge clk);
            check({name, "_done_single"}, 128'(done), 128'd0);
            check({name, "_idle_after"},  128'(busy), 128'd0);
        end
    endtask

    initial begin
        vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 128'h00112233445566778899AABBCCDDEEFF, -1};
        vecs[1] = '{128'h0123456789ABCDEFFEDCBA98765432A5, 128'h0123456789ABCDEFFEDCBA98765432A5, -1};
        vecs[2] = '{128'h07070707070707070707070707070707, 128'h07070707070707070707070707070707, -1};
        vecs[3] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, -1};
        vecs[4] = '{128'hDEADBEEFCAFEF00D0123456789ABCDEF, 128'hDEADBEEFCAFEF00D0123456789ABCDEF, 100};

        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_line", 128'(data_out_tx), 128'd1);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            data_in = vecs[v].data;
            start = 1'b1;
            check_block(vecs[v].exp, vecs[v].repulse, 1'b0, 1, $sformatf("vec%0d", v));
        end

        // Byte 15 = A5: explicit bit sequence of the last frame.
        begin
            logic [9:0] seq;
            logic [9:0] got;
            int         stable_err;
            seq = 10'b1101001010;
            got = 10'd0;
            stable_err = 0;
            data_in = 128'h000000000000000000000000000000A5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (15 * FB * N) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < N; c++) begin
                    if (c == 0) got[b] = data_out_tx;
                    else if (data_out_tx !== got[b]) stable_err++;
                    @(negedge clk);
                end
                if (FB == 11 && b == 8) repeat (N) @(negedge clk);
            end
            check("a5_bit_sequence", 128'(got), 128'(seq));
            check("a5_bit_hold", 128'(stable_err), 128'd0);
            repeat (4) @(negedge clk);
            check("a5_idle", 128'(busy), 128'd0);
        end

        // Start held high: two blocks, second start bit one cycle after done.
        data_in = 128'h00112233445566778899AABBCCDDEEFF;
        start = 1'b1;
        check_block(128'h00112233445566778899AABBCCDDEEFF, -1, 1'b1, 1, "hold1");
        check_block(128'h00112233445566778899AABBCCDDEEFF, -1, 1'b1, 1, "hold2");
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_idle", 128'(busy), 128'd0);

        // Reset mid-transfer aborts immediately, no done pulse.
        data_in = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (199) @(negedge clk);
        check("pre_rst_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        check("rst_line", 128'(data_out_tx), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        check("rst_done_hold", 128'(done), 128'd0);
        rst = 1'b0;
        start = 1'b1;
        data_in = 128'h8899AABBCCDDEEFF0011223344556677;
        @(negedge clk);
        check("rst_first_cycle_ignored", 128'(busy), 128'd0);
        check("rst_no_done", 128'(done), 128'd0);
        check_block(128'h8899AABBCCDDEEFF0011223344556677, -1, 1'b0, 1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
